writeback_arbiter: RTL
======================

Name: writeback_arbiter

Overview:
- Sits directly upstream of the register file's single write port and drives its DirC, WriteData and WriteEnable inputs.
- Merges two result sources into that one port: the ALU result bus and the memory-load return bus.
- Holds deferred ALU results in a small FIFO and keeps write-after-write ordering correct.
- Outputs are registered on the CLK rising edge, so they are stable while the register file commits during the CLK-low phase.

Parameters:
- DEPTH, 4, ALU deferral FIFO entries; power of two, at least 2.
- DATA_W, 32, result data width.
- ADDR_W, 4, register address width (16 registers).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- AluValid  input  1  ALU result present.
- AluDir  input  ADDR_W  ALU destination register.
- AluData  input  DATA_W  ALU result.
- AluReady  output  1  ALU result accepted this cycle when AluValid is also high.
- MemValid  input  1  load data present; always accepted, no ready.
- MemDir  input  ADDR_W  load destination register.
- MemData  input  DATA_W  load data.
- DirC  output  ADDR_W  register-file write address (registered).
- WriteData  output  DATA_W  register-file write data (registered).
- WriteEnable  output  1  register-file write strobe (registered).
- Pending  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, RST=1): DirC=0, WriteData=0, WriteEnable=0, FIFO emptied, Pending=0. AluReady=0 while RST is high.
- One write is issued per cycle at most. An accepted value appears on DirC/WriteData/WriteEnable after exactly one rising edge.
- Issue priority each cycle:
  1. MemValid: issue the memory result.
  2. FIFO not empty: pop the head and issue it.
  3. Otherwise, if AluValid and the FIFO is empty: issue the ALU result directly (bypass).
  4. Otherwise: WriteEnable=0 next cycle.
- ALU acceptance:
  - AluReady = not RST and (Pending < DEPTH, or a pop happens this cycle).
  - An accepted ALU result that is not issued directly is pushed to the FIFO tail, preserving ALU order.
  - An ALU result never bypasses non-empty FIFO contents.
- Ordering rule:
  - A memory result is program-order older than any ALU result presented in the same cycle.
  - A memory result is program-order younger than every entry already in the FIFO.
- Squash: when MemValid is issued, every FIFO entry present before this edge whose Dir equals MemDir is marked dead.
  - A same-cycle ALU push to the same Dir is not marked dead.
- Popping a dead entry consumes the cycle with WriteEnable=0 and still frees the slot.
- Simultaneous push and pop: Pending is unchanged. This is legal at Pending=DEPTH, because the pop frees the slot in the same edge.
- Full with MemValid high: nothing pops, so AluReady=0. The ALU must hold its result.
- Pointers wrap modulo DEPTH; Pending distinguishes full from empty.
- Reset asserted mid-operation: all pending writes are discarded, and outputs clear immediately.

Optional Feature:
- Macro: WB_FORWARD_EN.
- When defined, add:
  - Inputs QDirA and QDirB (ADDR_W each).
  - Outputs HitA and HitB (1 each) and FwdDataA and FwdDataB (DATA_W each).
- Forwarding is combinational. Sources are the output register (when WriteEnable=1) and the live FIFO entries.
- When several sources match, the youngest matching live value is forwarded. The output register counts as the oldest source.
- When not defined, these ports and the compare logic are absent.

Decomposition:
- Package wb_pkg holds:
  - Localparams for the default DATA_W, ADDR_W and DEPTH.
  - Typedef wb_entry_t: live bit, dir, data.
  - A function clog2_depth.
- One natural sub-module: wb_fifo. It is a DEPTH-entry circular buffer with push, pop and a parallel squash-by-address port. It exposes its entry array for the forwarding compare.

Test Plan:
- ALU bypass: reset, then AluValid with Dir=3, Data=0x11 and FIFO empty -> next edge DirC=3, WriteData=0x11, WriteEnable=1, Pending=0.
- Collision: same cycle MemValid (Dir=5, Data=0xAA) and AluValid (Dir=6, Data=0xBB) -> cycle+1 writes reg 5=0xAA, cycle+2 writes reg 6=0xBB; Pending goes 1 then 0.
- Squash: FIFO holds Dir=7, Data=0x1, then MemValid with Dir=7, Data=0x2 -> reg 7 written 0x2; the following pop gives WriteEnable=0; reg 7 is never rewritten with 0x1.
- Full/backpressure: hold MemValid high for DEPTH+2 cycles with a continuous AluValid stream -> AluReady drops once Pending=4; no ALU value is lost; the stream drains in order after MemValid falls.
- Reset mid-drain: RST asserted with Pending=3 -> WriteEnable=0 and Pending=0 immediately, without waiting for a clock edge; no stale write appears after release.
- WB_FORWARD_EN: FIFO holds Dir=2 entries with Data 0x10 then 0x20, QDirA=2 -> HitA=1, FwdDataA=0x20; QDirB=9 -> HitB=0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, FIFO entry type and sizing helper for the
// writeback arbiter. Optional forwarding is built with WB_FORWARD_EN.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 4;
   localparam int WB_DEPTH  = 4;

   typedef struct packed {
      logic                 live;
      logic [WB_ADDR_W-1:0] dir;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

   function automatic int clog2_depth(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/wb_if.sv
// wb_if: ALU/load inputs and register-file write port of the arbiter.
// WB_FORWARD_EN adds the two forwarding query/response pairs.
interface wb_if
   import wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W,
   parameter int DEPTH  = WB_DEPTH
);
   localparam int PW = clog2_depth(DEPTH) + 1;

   logic              AluValid;
   logic [ADDR_W-1:0] AluDir;
   logic [DATA_W-1:0] AluData;
   logic              AluReady;
   logic              MemValid;
   logic [ADDR_W-1:0] MemDir;
   logic [DATA_W-1:0] MemData;
   logic [ADDR_W-1:0] DirC;
   logic [DATA_W-1:0] WriteData;
   logic              WriteEnable;
   logic [PW-1:0]     Pending;
`ifdef WB_FORWARD_EN
   logic [ADDR_W-1:0] QDirA;
   logic [ADDR_W-1:0] QDirB;
   logic              HitA;
   logic              HitB;
   logic [DATA_W-1:0] FwdDataA;
   logic [DATA_W-1:0] FwdDataB;
`endif

   modport master (
`ifdef WB_FORWARD_EN
      output QDirA, QDirB,
      input  HitA, HitB, FwdDataA, FwdDataB,
`endif
      output AluValid, AluDir, AluData,
      output MemValid, MemDir, MemData,
      input  AluReady, DirC, WriteData, WriteEnable, Pending
   );

   modport slave (
`ifdef WB_FORWARD_EN
      input  QDirA, QDirB,
      output HitA, HitB, FwdDataA, FwdDataB,
`endif
      input  AluValid, AluDir, AluData,
      input  MemValid, MemDir, MemData,
      output AluReady, DirC, WriteData, WriteEnable, Pending
   );

endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of deferred ALU results with a parallel
// squash-by-address port; the entry array is exposed for forwarding.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   localparam int PTR_W = clog2_depth(DEPTH),
   localparam int PW    = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  wb_entry_t        push_entry,
   input  logic             pop,
   input  logic             squash_en,
   input  logic [WB_ADDR_W-1:0] squash_dir,
   output wb_entry_t        head,
   output logic [PW-1:0]    count,
   output logic [PTR_W-1:0] rd_ptr,
   output wb_entry_t        entries [DEPTH]
);

   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    cnt_q, cnt_d;

   // Squash old entries first so a same-edge push is never killed.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (squash_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].dir == squash_dir) begin
               mem_d[i].live = 1'b0;
            end
         end
      end
      if (push) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Expose state to the arbiter.
   always_comb begin
      head    = mem_q[rd_ptr_q];
      count   = cnt_q;
      rd_ptr  = rd_ptr_q;
      entries = mem_q;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges load and ALU results onto one registered
// register-file write port. WB_FORWARD_EN adds read forwarding.
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
) (
   input logic CLK,
   input logic RST,
   wb_if.slave bus
);
   localparam int PTR_W = clog2_depth(DEPTH);
   localparam int PW    = PTR_W + 1;
   localparam logic [PW-1:0] FULL = PW'(DEPTH);

   wb_entry_t         ents [DEPTH];
   wb_entry_t         head;
   wb_entry_t         alu_ent;
   logic [PW-1:0]     cnt;
   logic [PTR_W-1:0]  rd_ptr;
   logic              empty, pop, push, accept, bypass, alu_ready;
   logic [ADDR_W-1:0] dirc_q, dirc_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;

   // Acceptance: a pop frees a slot in the same edge it is refilled.
   always_comb begin
      alu_ent   = '{live: 1'b1, dir: bus.AluDir, data: bus.AluData};
      empty     = (cnt == '0);
      pop       = !bus.MemValid && !empty;
      alu_ready = !RST && ((cnt < FULL) || pop);
      accept    = bus.AluValid && alu_ready;
      bypass    = accept && !bus.MemValid && empty;
      push      = accept && !bypass;
   end

   // Issue select: load, then FIFO head, then bypassed ALU result.
   always_comb begin
      we_d    = 1'b0;
      dirc_d  = dirc_q;
      wdata_d = wdata_q;
      if (bus.MemValid) begin
         we_d    = 1'b1;
         dirc_d  = bus.MemDir;
         wdata_d = bus.MemData;
      end else if (!empty) begin
         we_d = head.live;
         if (head.live) begin
            dirc_d  = head.dir;
            wdata_d = head.data;
         end
      end else if (bypass) begin
         we_d    = 1'b1;
         dirc_d  = bus.AluDir;
         wdata_d = bus.AluData;
      end
   end

   // Registered write port, stable through the CLK-low commit.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dirc_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         dirc_q  <= dirc_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
      end
   end

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (CLK),
      .rst        (RST),
      .push       (push),
      .push_entry (alu_ent),
      .pop        (pop),
      .squash_en  (bus.MemValid),
      .squash_dir (bus.MemDir),
      .head       (head),
      .count      (cnt),
      .rd_ptr     (rd_ptr),
      .entries    (ents)
   );

   assign bus.AluReady    = alu_ready;
   assign bus.DirC        = dirc_q;
   assign bus.WriteData   = wdata_q;
   assign bus.WriteEnable = we_q;
   assign bus.Pending     = cnt;

`ifdef WB_FORWARD_EN
   logic [PTR_W-1:0] slot;

   // Oldest to youngest scan; later matches override earlier ones.
   always_comb begin
      bus.HitA     = 1'b0;
      bus.HitB     = 1'b0;
      bus.FwdDataA = '0;
      bus.FwdDataB = '0;
      slot         = rd_ptr;
      if (we_q && dirc_q == bus.QDirA) begin
         bus.HitA     = 1'b1;
         bus.FwdDataA = wdata_q;
      end
      if (we_q && dirc_q == bus.QDirB) begin
         bus.HitB     = 1'b1;
         bus.FwdDataB = wdata_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
         slot = rd_ptr + PTR_W'(k);
         if (PW'(k) < cnt && ents[slot].live) begin
            if (ents[slot].dir == bus.QDirA) begin
               bus.HitA     = 1'b1;
               bus.FwdDataA = ents[slot].data;
            end
            if (ents[slot].dir == bus.QDirB) begin
               bus.HitB     = 1'b1;
               bus.FwdDataB = ents[slot].data;
            end
         end
      end
   end
`else
   logic unused_fwd;

   // Entry array and read pointer only feed forwarding.
   always_comb begin
      unused_fwd = ^rd_ptr;
      for (int i = 0; i < DEPTH; i++) begin
         unused_fwd = unused_fwd ^ (^ents[i]);
      end
   end
`endif

endmodule
